// File: rtl/led_fade_sequencer.sv
// RGB keyframe sequencer: steps through a table of colour targets, fading each channel
// one LSB per tick toward the target, then holding. Optional macro GAMMA_EN squares outputs.
module led_fade_sequencer #(
    parameter int NUM_STEPS = 8,
    parameter int TICK_DIV  = 60000
) (
    input  logic                         iCLOCK,
    input  logic                         iRESET_n,
    input  logic                         iCFG_WE,
    input  logic [$clog2(NUM_STEPS)-1:0] iCFG_ADDR,
    input  logic [31:0]                  iCFG_DATA,
    input  logic [$clog2(NUM_STEPS)-1:0] iLAST,
    input  logic                         iLOOP,
    input  logic                         iSTART,
    input  logic                         iSTOP,
    output logic                         oBUSY,
    output logic [$clog2(NUM_STEPS)-1:0] oSTEP,
    output logic [7:0]                   oR,
    output logic [7:0]                   oG,
    output logic [7:0]                   oB,
    output logic                         oUPDATE,
    output logic                         oDONE
);

    localparam int SW = $clog2(NUM_STEPS);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FADE = 2'd1,
        S_HOLD = 2'd2,
        S_NEXT = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     table_q [NUM_STEPS];
    logic [31:0]     table_d [NUM_STEPS];
    logic [SW-1:0]   step_q, step_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      hold_q, hold_d;
    logic [7:0]      r_q, r_d, g_q, g_d, b_q, b_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            tick;
    logic            at_target;
    logic [31:0]     target;

    function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
        if (cur < tgt)      return cur + 8'd1;
        else if (cur > tgt) return cur - 8'd1;
        else                return cur;
    endfunction

    assign target    = table_q[step_q];
    assign tick      = (state_q != S_IDLE) && (cnt_q == TICK_LAST);
    assign at_target = (r_q == target[23:16]) && (g_q == target[15:8]) && (b_q == target[7:0]);

    always_comb begin
        state_d = state_q;
        table_d = table_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        r_d     = r_q;
        g_d     = g_q;
        b_d     = b_q;
        done_d  = 1'b0;

        if (iCFG_WE) table_d[iCFG_ADDR] = iCFG_DATA;

        if (state_q != S_IDLE) cnt_d = tick ? '0 : cnt_q + CW'(1);

        case (state_q)
            S_FADE: begin
                if (at_target) begin
                    state_d = S_HOLD;
                    hold_d  = target[31:24];
                end else if (tick) begin
                    r_d = step_toward(r_q, target[23:16]);
                    g_d = step_toward(g_q, target[15:8]);
                    b_d = step_toward(b_q, target[7:0]);
                end
            end
            S_HOLD: begin
                if (hold_q == 8'd0)  state_d = S_NEXT;
                else if (tick)       hold_d  = hold_q - 8'd1;
            end
            S_NEXT: begin
                if (step_q == iLAST) begin
                    if (iLOOP) begin
                        step_d  = '0;
                        state_d = S_FADE;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    // Power-of-two depth makes this wrap modulo NUM_STEPS.
                    step_d  = step_q + SW'(1);
                    state_d = S_FADE;
                end
            end
            default: ;
        endcase

        if (iSTART) begin
            state_d = S_FADE;
            step_d  = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
        end

        // Stop overrides everything, including a start or a tick in the same cycle.
        if (iSTOP) begin
            state_d = S_IDLE;
            step_d  = step_q;
            cnt_d   = '0;
            done_d  = 1'b0;
            r_d     = r_q;
            g_d     = g_q;
            b_d     = b_q;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge iCLOCK or negedge iRESET_n) begin
        if (!iRESET_n) begin
            state_q <= S_IDLE;
            for (int i = 0; i < NUM_STEPS; i++) table_q[i] <= '0;
            step_q  <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            table_q <= table_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign oBUSY = busy_q;
    assign oSTEP = step_q;
    assign oDONE = done_q;

`ifdef GAMMA_EN
    logic [15:0] sq_r, sq_g, sq_b;
    logic [7:0]  out_r_q, out_g_q, out_b_q;
    logic        upd_q, upd_d;

    assign sq_r  = 16'(r_q) * 16'(r_q);
    assign sq_g  = 16'(g_q) * 16'(g_q);
    assign sq_b  = 16'(b_q) * 16'(b_q);
    assign upd_d = {sq_r[15:8], sq_g[15:8], sq_b[15:8]} != {out_r_q, out_g_q, out_b_q};

    always_ff @(posedge iCLOCK or negedge iRESET_n) begin
        if (!iRESET_n) begin
            out_r_q <= '0;
            out_g_q <= '0;
            out_b_q <= '0;
            upd_q   <= 1'b0;
        end else begin
            out_r_q <= sq_r[15:8];
            out_g_q <= sq_g[15:8];
            out_b_q <= sq_b[15:8];
            upd_q   <= upd_d;
        end
    end

    assign oR      = out_r_q;
    assign oG      = out_g_q;
    assign oB      = out_b_q;
    assign oUPDATE = upd_q;
`else
    logic upd_q, upd_d;

    assign upd_d = {r_d, g_d, b_d} != {r_q, g_q, b_q};

    always_ff @(posedge iCLOCK or negedge iRESET_n) begin
        if (!iRESET_n) upd_q <= 1'b0;
        else           upd_q <= upd_d;
    end

    assign oR      = r_q;
    assign oG      = g_q;
    assign oB      = b_q;
    assign oUPDATE = upd_q;
`endif

endmodule

// File: tb/tb_led_fade_sequencer.sv
// Self-checking bench for led_fade_sequencer: a colour model pushes expected output
// values to a queue, and a monitor pops one on every oUPDATE strobe.
module tb_led_fade_sequencer;

    localparam int NS = 8;
    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic [2:0]  last;
    logic        loop_en;
    logic        start;
    logic        stop;
    logic        busy;
    logic [2:0]  step;
    logic [7:0]  o_r, o_g, o_b;
    logic        upd;
    logic        done;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [23:0] exp_q[$];
    logic [7:0]  m_r, m_g, m_b;
    logic [23:0] last_v;
    int          n_pushed;
    int          n_upd;

    always #5 clk = ~clk;

    led_fade_sequencer #(.NUM_STEPS(NS), .TICK_DIV(TD)) dut (
        .iCLOCK    (clk),
        .iRESET_n  (rst_n),
        .iCFG_WE   (cfg_we),
        .iCFG_ADDR (cfg_addr),
        .iCFG_DATA (cfg_data),
        .iLAST     (last),
        .iLOOP     (loop_en),
        .iSTART    (start),
        .iSTOP     (stop),
        .oBUSY     (busy),
        .oSTEP     (step),
        .oR        (o_r),
        .oG        (o_g),
        .oB        (o_b),
        .oUPDATE   (upd),
        .oDONE     (done)
    );

    function automatic logic [7:0] gamma(input logic [7:0] c);
        logic [15:0] sq;
        sq = 16'(c) * 16'(c);
        return sq[15:8];
    endfunction

    function automatic logic [23:0] model_out(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
`ifdef GAMMA_EN
        return {gamma(r), gamma(g), gamma(b)};
`else
        return {r, g, b};
`endif
    endfunction

    function automatic logic [7:0] step_to(input logic [7:0] c, input logic [7:0] t);
        if (c < t) return c + 8'd1;
        if (c > t) return c - 8'd1;
        return c;
    endfunction

    task automatic push_rgb(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        logic [23:0] v;
        m_r = r;
        m_g = g;
        m_b = b;
        v = model_out(r, g, b);
        if (v != last_v) begin
            exp_q.push_back(v);
            n_pushed++;
        end
        last_v = v;
    endtask

    // Model at most max_n ticks of fading from the current model colour toward a target.
    task automatic push_fade(input logic [7:0] tr, input logic [7:0] tg, input logic [7:0] tb, input int max_n);
        for (int i = 0; i < max_n; i++) begin
            if (m_r == tr && m_g == tg && m_b == tb) break;
            push_rgb(step_to(m_r, tr), step_to(m_g, tg), step_to(m_b, tb));
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_r = 8'd0;
        m_g = 8'd0;
        m_b = 8'd0;
        last_v = 24'd0;
        n_pushed = 0;
        n_upd = 0;
    endtask

    task automatic monitor();
        logic [23:0] e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && upd === 1'b1) begin
                n_upd++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL update_unexpected: got %06h, required no update", {o_r, o_g, o_b});
                end else begin
                    e = exp_q.pop_front();
                    if ({o_r, o_g, o_b} !== e) begin
                        n_err++;
                        $display("FAIL update_value: got %06h, required %06h", {o_r, o_g, o_b}, e);
                    end
                end
            end
        end
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int n, output bit seen);
        n = 0;
        seen = 1'b0;
        while (n < bound) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    // which: 0 = oR, 1 = oG, 2 = oSTEP
    task automatic wait_ch(input int which, input logic [7:0] v, input int bound, input string name);
        logic [7:0] obs;
        bit hit;
        hit = 1'b0;
        for (int n = 0; n < bound; n++) begin
            obs = (which == 0) ? o_r : (which == 1) ? o_g : {5'd0, step};
            if (obs === v) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (!hit) begin
            n_err++;
            $display("FAIL %s_timeout: got %0d, required %0d within %0d cycles", name, obs, v, bound);
        end
    endtask

    task automatic wait_q_empty(input int bound, input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_queue: got %0d pending, required 0", name, exp_q.size());
        end
    endtask

    task automatic check_idle_outputs(input string name);
        n_cmp++;
        if ({busy, step, o_r, o_g, o_b, upd, done} !== 37'd0) begin
            n_err++;
            $display("FAIL %s: got busy=%b step=%0d rgb=%06h upd=%b done=%b, required all 0",
                     name, busy, step, {o_r, o_g, o_b}, upd, done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_held");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset_released");
    endtask

    task automatic test_single_step();
        int n;
        bit seen;
        cfg_write(3'd0, {8'd2, 8'd3, 8'd0, 8'd0});
        last = 3'd0;
        loop_en = 1'b0;
        push_fade(8'd3, 8'd0, 8'd0, 255);
        pulse_start();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_busy_latency: got %b, required 1", busy);
        end
        wait_done(100, n, seen);
        n_cmp++;
        if (!seen || n != 22) begin
            n_err++;
            $display("FAIL single_done_time: got seen=%b cycle=%0d, required seen=1 cycle=22", seen, n);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_busy_end: got %b, required 0", busy);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || o_r !== 8'd3) begin
            n_err++;
            $display("FAIL single_after: got done=%b r=%0d, required done=0 r=3", done, o_r);
        end
        wait_q_empty(1, "single");
    endtask

    task automatic test_loop();
        logic [2:0] prev;
        int chg;
        int bad;
        bit saw_done;
        cfg_write(3'd0, {8'd0, 8'd2, 8'd0, 8'd0});
        cfg_write(3'd1, {8'd0, 8'd0, 8'd2, 8'd0});
        last = 3'd1;
        loop_en = 1'b1;
        push_fade(8'd2, 8'd0, 8'd0, 255);
        push_fade(8'd0, 8'd2, 8'd0, 255);
        push_fade(8'd2, 8'd0, 8'd0, 255);
        push_fade(8'd0, 8'd2, 8'd0, 255);
        pulse_start();
        prev = step;
        chg = 0;
        bad = 0;
        saw_done = 1'b0;
        for (int n = 0; n < 300 && exp_q.size() != 0; n++) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
            if (step !== prev) begin
                chg++;
                if (step > 3'd1 || step == prev) bad++;
                prev = step;
            end
        end
        pulse_stop();
        wait_q_empty(1, "loop");
        n_cmp++;
        if (chg != 3 || bad != 0 || saw_done) begin
            n_err++;
            $display("FAIL loop_steps: got changes=%0d bad=%0d done=%b, required 3/0/0", chg, bad, saw_done);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL loop_stopped: got busy=%b, required 0", busy);
        end
    endtask

    task automatic test_start_stop();
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL startstop_idle: got busy=%b, required 0", busy);
        end
        cfg_write(3'd0, {8'd0, 8'd10, 8'd0, 8'd0});
        last = 3'd0;
        loop_en = 1'b0;
        push_fade(8'd10, 8'd0, 8'd0, 5);
        pulse_start();
        wait_ch(0, 8'd5, 100, "stop_r5");
        pulse_stop();
        repeat (12) @(negedge clk);
        n_cmp++;
        if (o_r !== 8'd5 || busy !== 1'b0 || step !== 3'd0) begin
            n_err++;
            $display("FAIL stop_frozen: got r=%0d busy=%b step=%0d, required r=5 busy=0 step=0", o_r, busy, step);
        end
        wait_q_empty(1, "stop");
    endtask

    task automatic test_redirect();
        int n;
        bit seen;
        push_fade(8'd10, 8'd0, 8'd0, 1);
        pulse_start();
        wait_ch(0, 8'd6, 100, "redirect_r6");
        cfg_write(3'd0, {8'd0, 8'd2, 8'd0, 8'd0});
        push_fade(8'd2, 8'd0, 8'd0, 255);
        wait_done(100, n, seen);
        n_cmp++;
        if (!seen || o_r !== 8'd2) begin
            n_err++;
            $display("FAIL redirect_end: got done=%b r=%0d, required done=1 r=2", seen, o_r);
        end
        wait_q_empty(1, "redirect");
    endtask

    task automatic test_restart_busy();
        int n;
        bit seen;
        cfg_write(3'd0, {8'd0, 8'd4, 8'd0, 8'd0});
        cfg_write(3'd1, {8'd0, 8'd4, 8'd4, 8'd0});
        last = 3'd1;
        loop_en = 1'b0;
        push_fade(8'd4, 8'd0, 8'd0, 255);
        push_fade(8'd4, 8'd4, 8'd0, 1);
        push_fade(8'd4, 8'd0, 8'd0, 255);
        push_fade(8'd4, 8'd4, 8'd0, 255);
        pulse_start();
        wait_ch(1, 8'd1, 100, "restart_g1");
        pulse_start();
        n_cmp++;
        if (step !== 3'd0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL restart_state: got step=%0d busy=%b, required step=0 busy=1", step, busy);
        end
        wait_done(200, n, seen);
        n_cmp++;
        if (!seen || o_g !== 8'd4 || o_r !== 8'd4) begin
            n_err++;
            $display("FAIL restart_end: got done=%b rgb=%06h, required done=1 rgb=040400", seen, {o_r, o_g, o_b});
        end
        wait_q_empty(1, "restart");
    endtask

    task automatic test_last_below();
        logic [2:0] prev;
        int chg;
        bit seen;
        for (int i = 0; i < NS; i++) cfg_write(3'(i), {8'd0, 8'd4, 8'd4, 8'd0});
        last = 3'd7;
        loop_en = 1'b0;
        pulse_start();
        wait_ch(2, 8'd3, 100, "last_step3");
        last = 3'd1;
        prev = 3'd3;
        chg = 0;
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (step !== prev) begin
                chg++;
                prev = step;
            end
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!seen || chg != 6 || step !== 3'd1) begin
            n_err++;
            $display("FAIL last_wrap: got done=%b changes=%0d step=%0d, required 1/6/1", seen, chg, step);
        end
    endtask

    task automatic test_reset_mid_fade();
        int n;
        bit seen;
        cfg_write(3'd0, {8'd0, 8'd255, 8'd0, 8'd0});
        last = 3'd0;
        loop_en = 1'b0;
        push_fade(8'd255, 8'd0, 8'd0, 6);
        pulse_start();
        wait_q_empty(200, "midfade_pre");
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midfade_reset");
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        wait_done(20, n, seen);
        n_cmp++;
        if (!seen || n != 3) begin
            n_err++;
            $display("FAIL midfade_table_zero: got seen=%b cycle=%0d, required seen=1 cycle=3", seen, n);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (n_upd != 0 || o_r !== 8'd0) begin
            n_err++;
            $display("FAIL midfade_no_update: got updates=%0d r=%0d, required 0/0", n_upd, o_r);
        end
    endtask

    task automatic test_gamma();
        int n;
        bit seen;
        model_clear();
        cfg_write(3'd0, {8'd0, 8'd255, 8'd0, 8'd0});
        last = 3'd0;
        loop_en = 1'b0;
        push_fade(8'd255, 8'd0, 8'd0, 255);
        pulse_start();
        wait_done(1200, n, seen);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (!seen || o_r !== 8'd254) begin
            n_err++;
            $display("FAIL gamma_final: got done=%b r=%0d, required done=1 r=254", seen, o_r);
        end
        n_cmp++;
        if (n_upd != n_pushed) begin
            n_err++;
            $display("FAIL gamma_update_count: got %0d, required %0d", n_upd, n_pushed);
        end
        wait_q_empty(1, "gamma");
    endtask

    initial begin
        rst_n    = 1'b0;
        cfg_we   = 1'b0;
        cfg_addr = 3'd0;
        cfg_data = 32'd0;
        last     = 3'd0;
        loop_en  = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        model_clear();
        fork
            monitor();
        join_none
        @(negedge clk);
        test_reset();
`ifdef GAMMA_EN
        test_gamma();
`else
        test_single_step();
        test_loop();
        test_start_stop();
        test_redirect();
        test_restart_busy();
        test_last_below();
        test_reset_mid_fade();
`endif
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
